// File: rtl/joy_db15_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | joy_db15_pkg : shared DB15 frame constants and responder state encoding  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package joy_db15_pkg;

  localparam int DB15_FRAME_BITS  = 24;
  localparam int DB15_PLAYER_BITS = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } db15_state_e;

endpackage
`default_nettype wire

// File: rtl/joy_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | joy_sync_edge : 2-flop synchroniser plus one flop for rising-edge detect |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module joy_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [2:0] pipe_q;
  logic [2:0] pipe_d;

  always_comb begin
    pipe_d = {pipe_q[1:0], async_in};
  end

  // Reset to the inactive (high) level so a low pin after reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= 3'b111;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign sync_out = pipe_q[1];
  assign rise     = pipe_q[1] & ~pipe_q[2];

endmodule
`default_nettype wire

// File: rtl/joy_db15_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | joy_db15_responder : DB15 joystick shift-register responder for a host   |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module joy_db15_responder
  import joy_db15_pkg::*;
#(
  parameter int          FRAME_BITS = DB15_FRAME_BITS,
  parameter logic [15:0] TIMEOUT    = 16'd4800
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DB15_PLAYER_BITS-1:0] joystick1,
  input  logic [DB15_PLAYER_BITS-1:0] joystick2,
  input  logic                        JOY_CLK,
  input  logic                        JOY_LOAD,
  output logic                        JOY_DATA,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overrun
);

  localparam int SREG_W = 2 * DB15_PLAYER_BITS;
  localparam int CNT_W  = $clog2(FRAME_BITS + 1);

  logic              clk_sync_unused;
  logic              clk_rise;
  logic              load_sync;
  logic              load_rise;

  db15_state_e       state_q, state_d;
  logic [SREG_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       wdog_q, wdog_d;
  logic              joy_data_q, joy_data_d;
  logic              overrun_q, overrun_d;
  logic              in_frame;

  joy_sync_edge u_sync_clk (
    .clk      (clk),
    .reset    (reset),
    .async_in (JOY_CLK),
    .sync_out (clk_sync_unused),
    .rise     (clk_rise)
  );

  joy_sync_edge u_sync_load (
    .clk      (clk),
    .reset    (reset),
    .async_in (JOY_LOAD),
    .sync_out (load_sync),
    .rise     (load_rise)
  );

  assign in_frame = (state_q == ST_LOADED) || (state_q == ST_SHIFT);

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    wdog_d     = wdog_q;
    joy_data_d = joy_data_q;
    overrun_d  = overrun_q;

    // Load level wins over everything: keep sampling the buttons while it is low.
    if (!load_sync) begin
      sreg_d     = {joystick2, joystick1};
      cnt_d      = '0;
      wdog_d     = '0;
      joy_data_d = 1'b1;
      state_d    = ST_IDLE;
      if (in_frame) begin
        overrun_d = 1'b1;
      end
    end else if (load_rise) begin
      state_d    = ST_LOADED;
      cnt_d      = '0;
      wdog_d     = '0;
      joy_data_d = ~sreg_q[0];
    end else if (in_frame) begin
      if (clk_rise) begin
        sreg_d = {1'b0, sreg_q[SREG_W-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        wdog_d = '0;
        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
          state_d    = ST_DONE;
          joy_data_d = 1'b1;
        end else begin
          state_d    = ST_SHIFT;
          joy_data_d = ~sreg_q[1];
        end
      end else if (wdog_q == (TIMEOUT - 16'd1)) begin
        state_d    = ST_IDLE;
        wdog_d     = '0;
        joy_data_d = 1'b1;
      end else begin
        wdog_d = wdog_q + 16'd1;
      end
    end else begin
      state_d    = ST_IDLE;
      wdog_d     = '0;
      joy_data_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      wdog_q     <= '0;
      joy_data_q <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      wdog_q     <= wdog_d;
      joy_data_q <= joy_data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign JOY_DATA   = joy_data_q;
  assign busy       = in_frame;
  assign frame_done = (state_q == ST_DONE);
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_joy_db15_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_joy_db15_responder : directed self-checking bench for the responder   |
// | Revision              : 1.0                                              |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_joy_db15_responder;

  localparam logic [15:0] TB_TIMEOUT = 16'd40;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic [11:0] joystick1 = 12'h000;
  logic [11:0] joystick2 = 12'h000;
  logic        JOY_CLK   = 1'b0;
  logic        JOY_LOAD  = 1'b1;
  logic        JOY_DATA;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int checks     = 0;
  int failures   = 0;
  int fd_cycles  = 0;

  joy_db15_responder #(
    .FRAME_BITS (24),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_DATA   (JOY_DATA),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #10 clk = ~clk;

  // Count every clk cycle in which frame_done is high.
  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) fd_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clk();
    JOY_CLK = 1'b1;
    tick(4);
    JOY_CLK = 1'b0;
    tick(4);
  endtask

  task automatic do_load();
    JOY_LOAD = 1'b0;
    tick(4);
    JOY_LOAD = 1'b1;
    tick(4);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int          fd0;
    logic        ok;
    logic [23:0] word;

    // Reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check1("rst_data", JOY_DATA, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", frame_done, 1'b0);
    check1("rst_overrun", overrun, 1'b0);

    // Bit order and frame end
    joystick1 = 12'h001;
    joystick2 = 12'h000;
    do_load();
    check1("bo_bit0", JOY_DATA, 1'b0);
    check1("bo_busy", busy, 1'b1);
    pulse_clk();
    check1("bo_bit1", JOY_DATA, 1'b1);
    fd0 = fd_cycles;
    ok  = 1'b1;
    repeat (22) begin
      pulse_clk();
      if (JOY_DATA !== 1'b1) ok = 1'b0;
    end
    check1("bo_bits2_23_high", ok, 1'b1);
    check_int("bo_no_early_done", fd_cycles - fd0, 0);
    pulse_clk();
    check_int("fe_done_cycles", fd_cycles - fd0, 1);
    check1("fe_busy", busy, 1'b0);
    check1("fe_data", JOY_DATA, 1'b1);
    pulse_clk();
    check1("fe_25th_data", JOY_DATA, 1'b1);
    check_int("fe_25th_done", fd_cycles - fd0, 1);
    check1("fe_no_overrun", overrun, 1'b0);

    // Overrun, restart with new capture, latency and capture isolation
    joystick1 = 12'h0A5;
    do_load();
    repeat (10) pulse_clk();
    check1("ov_before", overrun, 1'b0);
    joystick1 = 12'h001;
    do_load();
    joystick1 = 12'hFFF;
    fd0 = fd_cycles;
    check1("ov_set", overrun, 1'b1);
    check1("ov_busy", busy, 1'b1);
    check1("ov_new_bit0", JOY_DATA, 1'b0);
    JOY_CLK = 1'b1;
    tick(2);
    check1("lat_not_yet", JOY_DATA, 1'b0);
    tick(1);
    check1("lat_updated", JOY_DATA, 1'b1);
    JOY_CLK = 1'b0;
    tick(4);
    repeat (22) pulse_clk();
    check_int("ov_no_early_done", fd_cycles - fd0, 0);
    check1("ov_busy_23", busy, 1'b1);
    pulse_clk();
    check_int("ov_done_after_24", fd_cycles - fd0, 1);
    check1("ov_idle", busy, 1'b0);

    // Watchdog timeout
    joystick1 = 12'h0F0;
    do_load();
    repeat (3) pulse_clk();
    check1("to_busy_before", busy, 1'b1);
    fd0 = fd_cycles;
    tick(int'(TB_TIMEOUT) + 1);
    check1("to_busy", busy, 1'b0);
    check1("to_data", JOY_DATA, 1'b1);
    check_int("to_no_done", fd_cycles - fd0, 0);

    // Reset mid-frame
    joystick1 = 12'h001;
    do_load();
    repeat (5) pulse_clk();
    check1("rm_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check1("rm_data", JOY_DATA, 1'b1);
    check1("rm_busy", busy, 1'b0);
    check1("rm_done", frame_done, 1'b0);
    check1("rm_overrun", overrun, 1'b0);
    pulse_clk();
    check1("rm_clk_no_load_data", JOY_DATA, 1'b1);
    check1("rm_clk_no_load_busy", busy, 1'b0);

    // Host loopback
    joystick1 = 12'h005;
    joystick2 = 12'h800;
    fd0 = fd_cycles;
    for (int f = 0; f < 100; f++) begin
      do_load();
      for (int b = 0; b < 24; b++) begin
        word[b] = ~JOY_DATA;
        pulse_clk();
      end
      check24("loopback_word", word, 24'h800005);
    end
    check_int("loopback_done_count", fd_cycles - fd0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/joy_db15_responder.md
JOY_DB15_RESPONDER -- requirements
Module: joy_db15_responder

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 24, the number of bits shifted per frame (2 players x 12).
REQ-002 SHALL have parameter TIMEOUT, default 16'd4800, the idle clk cycles without a JOY_CLK edge before a frame is abandoned.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port joystick1, input, 12, player-1 buttons, active-high, bits FEDCBAUDLR order as in the host decoder.
REQ-006 SHALL have port joystick2, input, 12, player-2 buttons, same encoding.
REQ-007 SHALL have port JOY_CLK, input, 1, asynchronous shift clock from the host.
REQ-008 SHALL have port JOY_LOAD, input, 1, asynchronous active-low parallel-load strobe from the host.
REQ-009 SHALL have port JOY_DATA, output, 1, serial data to the host, active-low (pressed = 0).
REQ-010 SHALL have port busy, output, 1, high while a frame is loaded or shifting.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse when the last frame bit has been shifted out.
REQ-012 SHALL have port overrun, output, 1, sticky flag set when JOY_LOAD asserts mid-frame; cleared only by reset.

Function
REQ-013 SHALL pass JOY_CLK and JOY_LOAD through 2-flop synchronisers, then a third flop for edge detection.
REQ-014 SHALL implement states IDLE, LOADED, SHIFT, DONE.
REQ-015 The design SHALL capture {joystick2, joystick1} into the 24-bit shift register in any state when the synchronised JOY_LOAD is low, and hold it there while JOY_LOAD stays low. Shift-register bit 0 SHALL be joystick1[0].
REQ-016 On the synchronised JOY_LOAD rising edge, the design SHALL enter LOADED, clear the bit counter, and drive JOY_DATA = ~sreg[0].
REQ-017 In LOADED or SHIFT, each synchronised JOY_CLK rising edge SHALL shift sreg right, fill with 0 (idle = released), increment the counter, and move to SHIFT.
REQ-018 JOY_DATA SHALL be registered and SHALL update exactly 3 clk cycles after a pin-level JOY_CLK or JOY_LOAD rising edge.
REQ-019 When the counter reaches FRAME_BITS, the design SHALL enter DONE, pulse frame_done for one cycle, and then go to IDLE.
REQ-020 In DONE and IDLE, JOY_DATA SHALL be 1, and further JOY_CLK edges SHALL be ignored (output stays 1).
REQ-021 A JOY_LOAD low while in LOADED or SHIFT SHALL set overrun, reload the register, and restart the frame; JOY_LOAD takes priority over a JOY_CLK edge in the same cycle.
REQ-022 A 16-bit watchdog SHALL reset on every JOY_CLK edge or load. If TIMEOUT cycles pass in LOADED or SHIFT, the design SHALL return to IDLE with no frame_done.
REQ-023 busy SHALL be high exactly in LOADED and SHIFT.
REQ-024 Changes on joystick1 or joystick2 after capture SHALL NOT affect the frame in progress.

Reset
REQ-025 On reset, the design SHALL set state = IDLE, sreg = 0, counter = 0, watchdog = 0, JOY_DATA = 1, busy = 0, frame_done = 0, and overrun = 0.
REQ-026 On reset, synchroniser flops SHALL be set to 1 (inactive), so no false edge is detected after reset.
REQ-027 Reset mid-frame SHALL abandon the frame, and the next frame SHALL require a fresh JOY_LOAD.

Structure
REQ-028 The state enum, DB15_FRAME_BITS = 24 and DB15_PLAYER_BITS = 12 SHALL live in shared package joy_db15_pkg, which the host decoder also uses.
REQ-029 A single sub-module, joy_sync_edge (2-flop sync + rising-edge detect, reset value 1), SHALL be instantiated twice.
REQ-030 There SHALL be no other sub-modules, and there SHALL be no combinational path from inputs to JOY_DATA.

Verification
REQ-031 Loopback: with the joy_db15 host model on clk = 48 MHz, joystick1 = 12'h005 and joystick2 = 12'h800, the host SHALL decode identical words for 100 consecutive frames.
REQ-032 Bit order: with joystick1 = 12'h001 and all others 0, then LOAD, JOY_DATA SHALL be 0. After 1 JOY_CLK it SHALL be 1, and it SHALL stay 1 for the remaining 22 bits.
REQ-033 Frame end: 24 JOY_CLK edges SHALL produce frame_done high for exactly 1 cycle and busy low. A 25th edge SHALL leave JOY_DATA = 1 and frame_done = 0.
REQ-034 Overrun: JOY_LOAD low after 10 shifts SHALL set overrun = 1. The frame SHALL restart with bit 0 of the newly captured inputs, and frame_done SHALL fire only after 24 new shifts.
REQ-035 Timeout: LOAD followed by 3 shifts and then no JOY_CLK for TIMEOUT+1 cycles SHALL give busy = 0, JOY_DATA = 1 and no frame_done pulse.
REQ-036 Reset mid-frame: reset asserted for 1 cycle after 5 shifts SHALL give all outputs at their REQ-025 values on the next cycle. A following JOY_CLK without LOAD SHALL leave JOY_DATA = 1.
